div_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 13 +
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 131 +++++++++++++
 tb/tb_div_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the iterative divider: FSM states and constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } div_state_t;

  localparam int DIV_ITER = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and try to subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The remainder is always below the divisor, so a clear top trial bit means it fits.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    trial   = shifted - {1'b0, divisor};
    qbit    = ~trial[WIDTH];
    rem_out = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider producing quotient/remainder for DIV/DIVU.
// Signed support is compiled in only when DIV_SIGNED_EN is defined.
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

  div_state_t       state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] remr;
  logic [WIDTH-1:0] rem_nxt;
  logic [4:0]       cnt;
  logic             qbit;
  logic             dz;
  logic [WIDTH-1:0] dvd_in;
  logic [WIDTH-1:0] dvs_in;

`ifdef DIV_SIGNED_EN
  logic qneg;
  logic rneg;

  always_comb begin
    dvd_in = (Sign && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_in = (Sign && divisor[WIDTH-1])  ? -divisor  : divisor;
  end
`else
  logic unused_sign;
  assign unused_sign = Sign;

  always_comb begin
    dvd_in = dividend;
    dvs_in = divisor;
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (remr),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (rem_nxt),
    .qbit    (qbit)
  );

  // The dividend register doubles as the quotient shift register; for a zero
  // divisor it keeps the raw dividend so FIX can return it as the remainder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      remr     <= '0;
      cnt      <= '0;
      dz       <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg     <= 1'b0;
      rneg     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            remr <= '0;
            cnt  <= '0;
            dvs  <= dvs_in;
            dz   <= (divisor == '0);
`ifdef DIV_SIGNED_EN
            qneg <= Sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg <= Sign & dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              dvd   <= dividend;
              state <= FIX;
            end else begin
              dvd   <= dvd_in;
              state <= RUN;
            end
          end
        end
        RUN: begin
          remr <= rem_nxt;
          dvd  <= {dvd[WIDTH-2:0], qbit};
          cnt  <= cnt + 5'd1;
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= dz;
          state    <= IDLE;
          if (dz) begin
            quot <= DIV_ZERO_QUOT;
            rem  <= dvd;
          end else begin
`ifdef DIV_SIGNED_EN
            quot <= qneg ? -dvd : dvd;
            rem  <= rneg ? -remr : remr;
`else
            quot <= dvd;
            rem  <= remr;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divisions against a plain-arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_zero;

  int tests = 0;
  int fails = 0;
  int edges;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Sign     (sgn),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  // Reference result from truncating integer division on 64-bit values.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb, lq, lr;
`ifndef DIV_SIGNED_EN
    s = 1'b0;
`endif
    if (b == 32'd0) begin
      q  = 32'hFFFFFFFF;
      r  = a;
      dz = 1'b1;
      return;
    end
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
    dz = 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; leaves at the negedge after the sampling edge.
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
    sgn      = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone();
    while (!done && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic        edz;
    model(s, a, b, eq, er, edz);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " latency"}, edges, edz ? 32'd2 : 32'd34);
    check({tag, " quot"}, quot, eq);
    check({tag, " rem"}, rem, er);
    check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic runOne(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(s, a, b);
    check({tag, " busy after start"}, {31'd0, busy}, 32'd1);
    waitDone();
    checkOutput(tag, s, a, b);
    @(negedge clk);
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int doneSeen;
    logic [31:0] ra, rb;
    logic        rs;

    rst = 1'b1;
    start = 1'b0;
    sgn = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quot", quot, 32'd0);
    check("reset rem", rem, 32'd0);
    check("reset div_zero", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runOne("divu 100/7", 1'b0, 32'd100, 32'd7);
    runOne("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2);
    runOne("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
    runOne("divu 1234/0", 1'b0, 32'd1234, 32'd0);
    runOne("div -5/0", 1'b1, 32'hFFFFFFFB, 32'd0);
    runOne("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1);
    runOne("div 7/-3", 1'b1, 32'd7, 32'hFFFFFFFD);

    // A start during a running division is dropped; a start in the done cycle is taken.
    applyStimulus(1'b0, 32'd1000, 32'd9);
    while (edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    sgn = 1'b0;
    dividend = 32'd55;
    divisor = 32'd0;
    start = 1'b1;
    @(posedge clk);
    edges++;
    @(negedge clk);
    start = 1'b0;
    waitDone();
    checkOutput("ignored start", 1'b0, 32'd1000, 32'd9);
    applyStimulus(1'b0, 32'd77, 32'd5);
    check("b2b busy", {31'd0, busy}, 32'd1);
    waitDone();
    checkOutput("b2b start", 1'b0, 32'd77, 32'd5);
    @(negedge clk);

    // Reset in the middle of RUN discards the operation.
    applyStimulus(1'b0, 32'd500, 32'd3);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst quot", quot, 32'd0);
    check("midrst rem", rem, 32'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    check("midrst no done", doneSeen, 32'd0);

    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      runOne($sformatf("rand%0d", i), rs, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
